// File: rtl/synth_pkg.sv
// Shared constants, FSM state type and pitch/glide helpers for the note phase sequencer.
package synth_pkg;

  localparam int unsigned NOTE_W = 7;
  localparam int unsigned INC_W  = 16;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [CTRL_W-1:0] PHASE_CTRL_HOLD = 4'b0000;
  localparam logic [CTRL_W-1:0] PHASE_CTRL_LOAD = 4'b1001;
  localparam logic [CTRL_W-1:0] PHASE_CTRL_STEP = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  // Top-octave increments for the twelve semitones, C upward.
  function automatic logic [INC_W-1:0] base_lut(input logic [3:0] semi);
    logic [INC_W-1:0] base;
    case (semi)
      4'd0:    base = 16'd32768;
      4'd1:    base = 16'd34716;
      4'd2:    base = 16'd36781;
      4'd3:    base = 16'd38968;
      4'd4:    base = 16'd41285;
      4'd5:    base = 16'd43740;
      4'd6:    base = 16'd46341;
      4'd7:    base = 16'd49097;
      4'd8:    base = 16'd52016;
      4'd9:    base = 16'd55109;
      4'd10:   base = 16'd58386;
      4'd11:   base = 16'd61858;
      default: base = 16'd32768;
    endcase
    return base;
  endfunction

  // Move cur toward tgt by rate without overshooting; rate 0 jumps straight to tgt.
  function automatic logic [INC_W-1:0] glide_step(input logic [INC_W-1:0] cur,
                                                  input logic [INC_W-1:0] tgt,
                                                  input logic [7:0]       rate);
    logic [INC_W-1:0] gap;
    logic [INC_W-1:0] nxt;
    gap = (cur < tgt) ? (tgt - cur) : (cur - tgt);
    if (rate == 8'd0 || gap <= INC_W'(rate)) begin
      nxt = tgt;
    end else if (cur < tgt) begin
      nxt = cur + INC_W'(rate);
    end else begin
      nxt = cur - INC_W'(rate);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/note_to_inc.sv
// Combinational note number to 16-bit phase increment (semitone table shifted per octave).
module note_to_inc (
  input  logic [6:0]  note_num,
  output logic [15:0] inc_c
);
  import synth_pkg::*;

  logic [3:0] octave_c;
  logic [3:0] semi_c;
  logic [3:0] shift_c;

  always_comb begin
    octave_c = 4'(note_num / 7'd12);
    semi_c   = 4'(note_num % 7'd12);
    shift_c  = 4'd10 - octave_c;
    inc_c    = base_lut(semi_c) >> shift_c;
  end

endmodule

// File: rtl/note_phase_seq.sv
// Note sequencer driving a downstream phase accumulator: load on new note, step once per sample tick.
// Optional NOTE_GLIDE_EN adds glide_rate and portamento between notes while sounding.
module note_phase_seq #(
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [6:0]  note_num,
  input  logic        note_off,
`ifdef NOTE_GLIDE_EN
  input  logic [7:0]  glide_rate,
`endif
  output logic [3:0]  phase_ctrl,
  output logic [15:0] phase_data,
  output logic        active
);
  import synth_pkg::*;

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] phase_ctrl_q, phase_ctrl_d;
  logic [INC_W-1:0]  phase_data_q, phase_data_d;
  logic              active_q, active_d;
  logic              note_ready_q, note_ready_d;
  logic [INC_W-1:0]  inc_c;
  logic              tick_c;
  logic              accept_c;
`ifdef NOTE_GLIDE_EN
  logic [INC_W-1:0]  target_q, target_d;
  logic              pend_q, pend_d;
`endif

  note_to_inc u_note_to_inc (
    .note_num (note_num),
    .inc_c    (inc_c)
  );

  assign tick_c   = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign accept_c = note_valid && note_ready_q;

  // Next-state and registered-output decode; steps are emitted the cycle after a tick seen in RUN.
  always_comb begin
    cnt_d        = tick_c ? '0 : cnt_q + CNT_W'(1);
    state_d      = state_q;
    phase_ctrl_d = PHASE_CTRL_HOLD;
    phase_data_d = phase_data_q;
`ifdef NOTE_GLIDE_EN
    target_d     = accept_c ? inc_c : target_q;
    pend_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d      = ST_LOAD;
          phase_ctrl_d = PHASE_CTRL_LOAD;
          phase_data_d = inc_c;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
`ifdef NOTE_GLIDE_EN
        // A new note only retargets the glide; the pending load follows the step that set it.
        if (note_off && !accept_c) begin
          state_d = ST_IDLE;
        end else if (pend_q) begin
          phase_ctrl_d = PHASE_CTRL_LOAD;
          phase_data_d = glide_step(phase_data_q, target_d, glide_rate);
        end else if (tick_c) begin
          phase_ctrl_d = PHASE_CTRL_STEP;
          pend_d       = (phase_data_q != target_d);
        end
`else
        if (accept_c) begin
          state_d      = ST_LOAD;
          phase_ctrl_d = PHASE_CTRL_LOAD;
          phase_data_d = inc_c;
        end else if (note_off) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          phase_ctrl_d = PHASE_CTRL_STEP;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    note_ready_d = (state_d != ST_LOAD);
    // A retrigger keeps the note sounding through its reload cycle.
    active_d     = (state_d == ST_RUN) || (state_d == ST_LOAD && state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      phase_ctrl_q <= PHASE_CTRL_HOLD;
      phase_data_q <= '0;
      active_q     <= 1'b0;
      note_ready_q <= 1'b0;
`ifdef NOTE_GLIDE_EN
      target_q     <= '0;
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_ctrl_q <= phase_ctrl_d;
      phase_data_q <= phase_data_d;
      active_q     <= active_d;
      note_ready_q <= note_ready_d;
`ifdef NOTE_GLIDE_EN
      target_q     <= target_d;
      pend_q       <= pend_d;
`endif
    end
  end

  assign phase_ctrl = phase_ctrl_q;
  assign phase_data = phase_data_q;
  assign active     = active_q;
  assign note_ready = note_ready_q;

endmodule

// File: tb/tb_note_phase_seq.sv
// Directed self-checking bench for note_phase_seq with a short tick period.
module tb_note_phase_seq;

  localparam int TD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [6:0]  note_num = 7'd0;
  logic        note_off = 1'b0;
  logic [3:0]  phase_ctrl;
  logic [15:0] phase_data;
  logic        active;
`ifdef NOTE_GLIDE_EN
  logic [7:0]  glide_rate = 8'd0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  note_phase_seq #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_num   (note_num),
    .note_off   (note_off),
`ifdef NOTE_GLIDE_EN
    .glide_rate (glide_rate),
`endif
    .phase_ctrl (phase_ctrl),
    .phase_data (phase_data),
    .active     (active)
  );

  always #5 clk = ~clk;

  // cyc equals the DUT tick counter: zeroed by a reset edge, +1 per normal edge.
  task automatic tick_clk();
    @(posedge clk);
    #1;
    if (reset) cyc = 0;
    else cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; note_valid = 1'b1; note_num = 7'd69; note_off = 1'b0;
    tick_clk(); tick_clk();
    total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", phase_ctrl); end
    total++; if (phase_data !== 16'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", phase_data); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
    total++; if (note_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", note_ready); end
    reset = 1'b0; note_valid = 1'b0;
    tick_clk();
    total++; if (note_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", note_ready); end
    total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL post_reset_ctrl got=%b want=0000", phase_ctrl); end
  endtask

  task automatic test_note_69();
    int steps;
    logic [3:0] exp;
    note_num = 7'd69; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    total++; if (phase_ctrl !== 4'b1001) begin bad++; $display("FAIL n69_load_ctrl got=%b want=1001", phase_ctrl); end
    total++; if (phase_data !== 16'd1722) begin bad++; $display("FAIL n69_data got=%0d want=1722", phase_data); end
    total++; if (note_ready !== 1'b0) begin bad++; $display("FAIL n69_ready_in_load got=%b want=0", note_ready); end
    steps = 0;
    for (int i = 0; i < 22; i++) begin
      tick_clk();
      exp = (cyc % TD == 0) ? 4'b0001 : 4'b0000;
      total++; if (phase_ctrl !== exp) begin bad++; $display("FAIL n69_run_ctrl cyc=%0d got=%b want=%b", cyc, phase_ctrl, exp); end
      if (phase_ctrl === 4'b0001) steps++;
    end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL n69_active got=%b want=1", active); end
    total++; if (note_ready !== 1'b1) begin bad++; $display("FAIL n69_ready_run got=%b want=1", note_ready); end
    total++; if (steps != 3) begin bad++; $display("FAIL n69_step_count got=%0d want=3", steps); end
  endtask

  task automatic test_note_off();
    int steps;
    note_off = 1'b1;
    tick_clk();
    note_off = 1'b0;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL off_active got=%b want=0", active); end
    total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL off_ctrl got=%b want=0000", phase_ctrl); end
    total++; if (phase_data !== 16'd1722) begin bad++; $display("FAIL off_data_hold got=%0d want=1722", phase_data); end
    steps = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      note_off = (i == 3);
      tick_clk();
      total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL off_idle_ctrl cyc=%0d got=%b want=0000", cyc, phase_ctrl); end
      if (phase_ctrl === 4'b0001) steps++;
    end
    note_off = 1'b0;
    total++; if (steps != 0) begin bad++; $display("FAIL off_step_count got=%0d want=0", steps); end
  endtask

  task automatic test_boundary_notes();
    note_num = 7'd127; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    total++; if (phase_data !== 16'd49097) begin bad++; $display("FAIL n127_data got=%0d want=49097", phase_data); end
    total++; if (phase_ctrl !== 4'b1001) begin bad++; $display("FAIL n127_ctrl got=%b want=1001", phase_ctrl); end
    tick_clk();
    note_num = 7'd0; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    total++; if (phase_data !== 16'd32) begin bad++; $display("FAIL n0_data got=%0d want=32", phase_data); end
    total++; if (phase_ctrl !== 4'b1001) begin bad++; $display("FAIL n0_ctrl got=%b want=1001", phase_ctrl); end
    tick_clk();
    note_off = 1'b1;
    tick_clk();
    note_off = 1'b0;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL n0_off_active got=%b want=0", active); end
  endtask

  task automatic test_retrigger();
    note_num = 7'd69; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    tick_clk();
    note_num = 7'd60; note_valid = 1'b1; note_off = 1'b1;
    tick_clk();
    note_valid = 1'b0; note_off = 1'b0;
    total++; if (phase_ctrl !== 4'b1001) begin bad++; $display("FAIL retrig_ctrl got=%b want=1001", phase_ctrl); end
    total++; if (phase_data !== 16'd1024) begin bad++; $display("FAIL retrig_data got=%0d want=1024", phase_data); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL retrig_active_load got=%b want=1", active); end
    total++; if (note_ready !== 1'b0) begin bad++; $display("FAIL retrig_ready got=%b want=0", note_ready); end
    tick_clk();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL retrig_active_run got=%b want=1", active); end
    total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL retrig_run_ctrl got=%b want=0000", phase_ctrl); end
    note_off = 1'b1;
    tick_clk();
    note_off = 1'b0;
  endtask

  task automatic test_tick_in_load();
    logic [3:0] exp;
    for (int i = 0; i < TD && (cyc % TD) != TD - 2; i++) tick_clk();
    total++; if ((cyc % TD) != TD - 2) begin bad++; $display("FAIL til_align got=%0d want=%0d", cyc % TD, TD - 2); end
    note_num = 7'd12; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    total++; if (phase_ctrl !== 4'b1001) begin bad++; $display("FAIL til_load_ctrl got=%b want=1001", phase_ctrl); end
    total++; if (phase_data !== 16'd64) begin bad++; $display("FAIL til_data got=%0d want=64", phase_data); end
    total++; if (note_ready !== 1'b0) begin bad++; $display("FAIL til_ready_load got=%b want=0", note_ready); end
    tick_clk();
    total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL til_dropped_step got=%b want=0000", phase_ctrl); end
    for (int i = 0; i < TD; i++) begin
      tick_clk();
      exp = (cyc % TD == 0) ? 4'b0001 : 4'b0000;
      total++; if (phase_ctrl !== exp) begin bad++; $display("FAIL til_run_ctrl cyc=%0d got=%b want=%b", cyc, phase_ctrl, exp); end
      total++; if (note_ready !== 1'b1) begin bad++; $display("FAIL til_ready_run cyc=%0d got=%b want=1", cyc, note_ready); end
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < TD && (cyc % TD) != TD - 2; i++) tick_clk();
    reset = 1'b1;
    tick_clk();
    total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL rrun_ctrl got=%b want=0000", phase_ctrl); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rrun_active got=%b want=0", active); end
    total++; if (note_ready !== 1'b0) begin bad++; $display("FAIL rrun_ready got=%b want=0", note_ready); end
    tick_clk();
    reset = 1'b0;
    tick_clk();
    total++; if (note_ready !== 1'b1) begin bad++; $display("FAIL rrun_ready_after got=%b want=1", note_ready); end
    note_num = 7'd69; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    reset = 1'b1;
    tick_clk();
    reset = 1'b0;
    total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL rload_ctrl got=%b want=0000", phase_ctrl); end
    total++; if (phase_data !== 16'd0) begin bad++; $display("FAIL rload_data got=%0d want=0", phase_data); end
    for (int i = 0; i < 3 * TD; i++) begin
      tick_clk();
      total++; if (phase_ctrl !== 4'b0000) begin bad++; $display("FAIL rload_quiet cyc=%0d got=%b want=0000", cyc, phase_ctrl); end
    end
    total++; if (note_ready !== 1'b1) begin bad++; $display("FAIL rload_ready got=%b want=1", note_ready); end
  endtask

`ifdef NOTE_GLIDE_EN
  task automatic test_glide();
    int loads;
    logic [15:0] exp;
    logic [3:0] prev;
    glide_rate = 8'd100;
    note_num = 7'd60; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    total++; if (phase_data !== 16'd1024) begin bad++; $display("FAIL glide_first got=%0d want=1024", phase_data); end
    tick_clk();
    note_num = 7'd72; note_valid = 1'b1;
    tick_clk();
    note_valid = 1'b0;
    total++; if (note_ready !== 1'b1) begin bad++; $display("FAIL glide_no_load got=%b want=1", note_ready); end
    loads = 0; exp = 16'd1024; prev = phase_ctrl;
    for (int i = 0; i < 14 * TD; i++) begin
      tick_clk();
      if (phase_ctrl === 4'b1001) begin
        exp = (exp + 16'd100 >= 16'd2048) ? 16'd2048 : exp + 16'd100;
        loads++;
        total++; if (prev !== 4'b0001) begin bad++; $display("FAIL glide_pair got=%b want=0001", prev); end
        total++; if (phase_data !== exp) begin bad++; $display("FAIL glide_val got=%0d want=%0d", phase_data, exp); end
      end
      prev = phase_ctrl;
    end
    total++; if (loads != 11) begin bad++; $display("FAIL glide_loads got=%0d want=11", loads); end
    total++; if (phase_data !== 16'd2048) begin bad++; $display("FAIL glide_final got=%0d want=2048", phase_data); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef NOTE_GLIDE_EN
    test_glide();
`else
    test_note_69();
    test_note_off();
    test_boundary_notes();
    test_retrigger();
    test_tick_in_load();
    test_reset_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
